// File: rtl/spm_pkg.sv
// Shared types and defaults for the single-port SPM access controller.
// Responses and in-flight tags travel through the controller in these forms.
package spm_pkg;

    localparam int unsigned SpmDefaultDataWidth = 128;
    localparam int unsigned SpmDefaultRspDepth  = 2;

    typedef struct packed {
        logic [SpmDefaultDataWidth-1:0] rdata;
        logic                           write;
        logic                           err;
    } spm_rsp_t;

    typedef struct packed {
        logic valid;
        logic write;
        logic err;
    } spm_infl_t;

endpackage

// File: rtl/spm_rsp_fifo.sv
// Small registered response FIFO with no fall-through.
// The head is always read from storage, so data_o is stable while the FIFO is not popped.
module spm_rsp_fifo #(
    parameter int unsigned Depth = 2,
    parameter type elem_t = logic,
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  elem_t               data_i,
    input  logic                pop_i,
    output elem_t               data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] cnt_o
);

    elem_t                mem_d [Depth];
    elem_t                mem_q [Depth];
    logic [PtrWidth-1:0]  wr_ptr_d, wr_ptr_q;
    logic [PtrWidth-1:0]  rd_ptr_d, rd_ptr_q;
    logic [CntWidth-1:0]  cnt_d, cnt_q;
    logic                 push_ok;
    logic                 pop_ok;

    // Pointers wrap explicitly so Depth need not be a power of two.
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        return (32'(ptr) == Depth - 1) ? '0 : ptr + PtrWidth'(1);
    endfunction

    assign full_o  = (32'(cnt_q) == Depth);
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/spm_1p_access_ctrl.sv
// Valid/ready front-end for a single-port, 1-cycle-latency SPM macro.
// Issues macro strobes on accept and returns in-order responses through a credit-bounded buffer.
module spm_1p_access_ctrl
    import spm_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = SpmDefaultDataWidth,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned RspDepth  = SpmDefaultRspDepth,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_strb_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_write_o,
    output logic                 rsp_err_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [BeWidth-1:0]   mem_be_o,
    input  logic [DataWidth-1:0] mem_rdata_i
);

    localparam int unsigned CntWidth = $clog2(RspDepth + 1);

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 write;
        logic                 err;
    } rsp_t;

    spm_infl_t           infl_d, infl_q;
    logic                accept;
    logic                in_range;
    logic                buf_push;
    logic                buf_pop;
    logic                buf_full;
    logic                buf_empty;
    logic [CntWidth-1:0] buf_cnt;
    rsp_t                buf_head;
    rsp_t                live_rsp;
    rsp_t                rsp_out;

    // Every accepted or in-flight access owns a buffer slot, so pushes can never overflow.
    assign req_ready_o = ~buf_full & ((32'(buf_cnt) + 32'(infl_q.valid)) < RspDepth);
    assign accept      = req_valid_i & req_ready_o;
    assign in_range    = (32'(req_addr_i) < NumWords);

    always_comb begin
        mem_req_o   = accept & in_range;
        mem_we_o    = mem_req_o & req_write_i;
        mem_addr_o  = mem_req_o ? req_addr_i : '0;
        mem_wdata_o = mem_we_o ? req_wdata_i : '0;
        mem_be_o    = mem_we_o ? req_strb_i : '0;
    end

    always_comb begin
        infl_d = '0;
        if (accept) begin
            infl_d.valid = 1'b1;
            infl_d.write = req_write_i;
            infl_d.err   = ~in_range;
        end
    end

    // Macro read data exists for one cycle only; it is either forwarded now or captured.
    always_comb begin
        live_rsp       = '0;
        live_rsp.write = infl_q.write;
        live_rsp.err   = infl_q.err;
        if (infl_q.valid && !infl_q.write && !infl_q.err) begin
            live_rsp.rdata = mem_rdata_i;
        end
    end

    assign buf_push = infl_q.valid & ~(buf_empty & rsp_ready_i);
    assign buf_pop  = ~buf_empty & rsp_ready_i;

    always_comb begin
        rsp_valid_o = ~buf_empty | infl_q.valid;
        rsp_out     = buf_empty ? live_rsp : buf_head;
        rsp_rdata_o = rsp_out.rdata;
        rsp_write_o = rsp_out.write;
        rsp_err_o   = rsp_out.err;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            infl_q <= '0;
        end else begin
            infl_q <= infl_d;
        end
    end

    spm_rsp_fifo #(
        .Depth  (RspDepth),
        .elem_t (rsp_t)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (buf_push),
        .data_i  (live_rsp),
        .pop_i   (buf_pop),
        .data_o  (buf_head),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .cnt_o   (buf_cnt)
    );

endmodule

// File: tb/tb_spm_1p_access_ctrl.sv
// Scoreboard bench: a driver pushes expected responses from a reference memory,
// a forked monitor pops and compares them whenever the controller hands over a response.
module tb_spm_1p_access_ctrl;

    localparam int unsigned NW  = 1000;
    localparam int unsigned DW  = 128;
    localparam int unsigned BYW = 8;
    localparam int unsigned RD  = 2;
    localparam int unsigned AW  = 10;
    localparam int unsigned BW  = 16;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          write;
        logic          err;
    } exp_t;

    logic          clk_i;
    logic          rst_ni;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_write_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic [BW-1:0] req_strb_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_write_o;
    logic          rsp_err_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [BW-1:0] mem_be_o;
    logic [DW-1:0] mem_rdata_i;

    bit   [DW-1:0] macro_mem [NW];
    bit   [DW-1:0] ref_mem   [NW];
    exp_t          exp_q [$];
    int            checks;
    int            errors;
    bit            rand_mode;

    spm_1p_access_ctrl #(
        .NumWords  (NW),
        .DataWidth (DW),
        .ByteWidth (BYW),
        .RspDepth  (RD)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_strb_i  (req_strb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_write_o (rsp_write_o),
        .rsp_err_o   (rsp_err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_rdata_i (mem_rdata_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Macro model: read data is valid only the cycle after a request, garbage otherwise.
    always @(posedge clk_i) begin
        if (mem_req_o) begin
            mem_rdata_i <= macro_mem[mem_addr_o];
            if (mem_we_o) begin
                for (int b = 0; b < BW; b++) begin
                    if (mem_be_o[b]) macro_mem[mem_addr_o][b*BYW +: BYW] <= mem_wdata_o[b*BYW +: BYW];
                end
            end
        end else begin
            mem_rdata_i <= {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rand_mode) rsp_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    // Drives one request until accepted; the expected response comes from the reference memory.
    task automatic applyStimulus(input logic wr, input int unsigned addr, input logic [DW-1:0] wdata,
                                 input logic [BW-1:0] strb, output int waited);
        exp_t e;
        logic ok;
        waited      = 0;
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = AW'(addr);
        req_wdata_i = wdata;
        req_strb_i  = strb;
        while (!req_ready_o && waited < 100) begin
            tick();
            waited++;
        end
        if (!req_ready_o) begin
            checkOutput("req_accept_timeout", 0, 1);
            req_valid_i = 1'b0;
            return;
        end
        #1;
        ok = (addr < NW);
        checkOutput("mem_req", mem_req_o, ok);
        if (ok) begin
            checkOutput("mem_we", mem_we_o, wr);
            checkOutput("mem_addr", mem_addr_o, addr);
            checkOutput("mem_be", mem_be_o, wr ? strb : '0);
            if (wr) checkOutput("mem_wdata", mem_wdata_o, wdata);
        end
        e.write = wr;
        e.err   = ~ok;
        e.rdata = '0;
        if (ok && wr) begin
            for (int b = 0; b < BW; b++) begin
                if (strb[b]) ref_mem[addr][b*BYW +: BYW] = wdata[b*BYW +: BYW];
            end
        end
        if (ok && !wr) e.rdata = ref_mem[addr];
        exp_q.push_back(e);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic monitorLoop();
        exp_t          e;
        logic          hold_v;
        logic [DW-1:0] hold_rdata;
        logic          hold_write;
        logic          hold_err;
        hold_v = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    checkOutput("rsp_hold_valid", rsp_valid_o, 1);
                    checkOutput("rsp_hold_rdata", rsp_rdata_o, hold_rdata);
                    checkOutput("rsp_hold_write", rsp_write_o, hold_write);
                    checkOutput("rsp_hold_err", rsp_err_o, hold_err);
                end
                if (rsp_valid_o && rsp_ready_i) begin
                    hold_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        checkOutput("rsp_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("rsp_rdata", rsp_rdata_o, e.rdata);
                        checkOutput("rsp_write", rsp_write_o, e.write);
                        checkOutput("rsp_err", rsp_err_o, e.err);
                    end
                end else if (rsp_valid_o) begin
                    hold_v     = 1'b1;
                    hold_rdata = rsp_rdata_o;
                    hold_write = rsp_write_o;
                    hold_err   = rsp_err_o;
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    endtask

    initial begin : main
        int            waited;
        int unsigned   ra;
        logic [DW-1:0] rdat;
        logic [DW-1:0] pat_a5;
        logic [DW-1:0] pat_ff;
        logic [DW-1:0] exp_partial;

        checks      = 0;
        errors      = 0;
        rand_mode   = 1'b0;
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_strb_i  = '0;
        rsp_ready_i = 1'b1;
        pat_a5      = {16{8'hA5}};
        pat_ff      = {16{8'hFF}};
        exp_partial = {{15{8'hFF}}, 8'h00};

        fork
            monitorLoop();
        join_none

        #1;
        checkOutput("reset_req_ready", req_ready_o, 1);
        checkOutput("reset_rsp_valid", rsp_valid_o, 0);
        checkOutput("reset_mem_req", mem_req_o, 0);
        checkOutput("reset_rsp_rdata", rsp_rdata_o, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        $display("[TB] read after full write");
        applyStimulus(1'b1, 5, pat_a5, '1, waited);
        applyStimulus(1'b0, 5, '0, '0, waited);
        checkOutput("t1_rsp_valid_latency", rsp_valid_o, 1);
        checkOutput("t1_rsp_rdata", rsp_rdata_o, pat_a5);
        checkOutput("t1_rsp_write", rsp_write_o, 0);
        tick();

        $display("[TB] partial write");
        applyStimulus(1'b1, 7, pat_ff, '1, waited);
        applyStimulus(1'b1, 7, '0, 16'h0001, waited);
        applyStimulus(1'b0, 7, '0, '0, waited);
        checkOutput("t2_rsp_rdata", rsp_rdata_o, exp_partial);
        applyStimulus(1'b1, 9, pat_ff, '0, waited);
        tick();

        $display("[TB] streaming reads");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, i, '0, '0, waited);
            checkOutput("t3_stream_no_stall", waited, 0);
        end
        tick();
        tick();

        $display("[TB] backpressure");
        rsp_ready_i = 1'b0;
        applyStimulus(1'b0, 20, '0, '0, waited);
        checkOutput("t4_first_no_stall", waited, 0);
        applyStimulus(1'b0, 21, '0, '0, waited);
        checkOutput("t4_second_no_stall", waited, 0);
        checkOutput("t4_ready_low", req_ready_o, 0);
        tick();
        checkOutput("t4_ready_still_low", req_ready_o, 0);
        rsp_ready_i = 1'b1;
        tick();
        checkOutput("t4_ready_after_pop", req_ready_o, 1);
        applyStimulus(1'b0, 22, '0, '0, waited);
        checkOutput("t4_third_no_stall", waited, 0);
        tick();
        tick();

        $display("[TB] out of range access");
        applyStimulus(1'b0, 3, '0, '0, waited);
        applyStimulus(1'b0, 1000, '0, '0, waited);
        applyStimulus(1'b1, 1023, pat_ff, '1, waited);
        applyStimulus(1'b0, 4, '0, '0, waited);
        tick();
        tick();

        $display("[TB] reset with buffered responses");
        rsp_ready_i = 1'b0;
        applyStimulus(1'b0, 8, '0, '0, waited);
        applyStimulus(1'b0, 9, '0, '0, waited);
        tick();
        checkOutput("t6_buffered_valid", rsp_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("t6_rsp_valid_drop", rsp_valid_o, 0);
        checkOutput("t6_req_ready_reset", req_ready_o, 1);
        exp_q.delete();
        tick();
        tick();
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t6_no_stale_rsp", rsp_valid_o, 0);
            checkOutput("t6_ready_after_reset", req_ready_o, 1);
        end

        $display("[TB] randomized traffic");
        rand_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                tick();
            end else begin
                ra   = ($urandom_range(0, 9) == 0) ? 1000 + $urandom_range(0, 23) : $urandom_range(0, 15);
                rdat = {$urandom(), $urandom(), $urandom(), $urandom()};
                applyStimulus(1'($urandom_range(0, 1)), ra, rdat, BW'($urandom()), waited);
            end
        end

        rand_mode   = 1'b0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        tick();
        checkOutput("drain_scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
